axi4_lite_master: RTL and testbench
===================================

Name: axi4_lite_master

Overview:
- Synthesizable AXI4-Lite initiator: turns a simple single-beat command/response port into AXI4-Lite read and write transactions.
- Drives the same channel set the bench's AXI4-Lite driver drives (AW, W, B, AR, R), so it can replace the bench driver in front of the peripheral slave and serve as the on-chip master for integration tests.
- Exactly one transaction in flight at a time. A registered response buffer holds each result until the client consumes it.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR/ARADDR and cmd_addr
- DATA_WIDTH, 32, width of WDATA/RDATA and the command/response data; WSTRB is DATA_WIDTH/8 bits

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes
- cmd_prot  in  3  AxPROT value
- rsp_valid  out  1  response available
- rsp_ready  in  1  client consumes response
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP copy
- err_count  out  8  saturating count of non-OKAY responses
- AWADDR out ADDR_WIDTH; AWPROT out 3; AWVALID out 1; AWREADY in 1
- WDATA out DATA_WIDTH; WSTRB out DATA_WIDTH/8; WVALID out 1; WREADY in 1
- BRESP in 2; BVALID in 1; BREADY out 1
- ARADDR out ADDR_WIDTH; ARPROT out 3; ARVALID out 1; ARREADY in 1
- RDATA in DATA_WIDTH; RRESP in 2; RVALID in 1; RREADY out 1

Behaviour:
- Reset (ARESETn low, async): state = IDLE. All VALID/READY outputs are 0. Address, data, strobe, prot, rsp_* and err_count are 0. cmd_ready is 0 while reset is asserted.
- States:
  - IDLE
  - WR_REQ: AW and/or W pending
  - WR_RESP
  - RD_REQ
  - RD_RESP
  - RSP: response held
- cmd_ready = (state == IDLE) && ARESETn. It is combinational from the state.
- IDLE, on cmd accept: register addr, wdata, wstrb and prot.
  - Write: go to WR_REQ with AWVALID = 1 and WVALID = 1.
  - Read: go to RD_REQ with ARVALID = 1.
  - The VALIDs are visible in the cycle after acceptance.
- WR_REQ:
  - AWVALID drops the cycle after AWVALID && AWREADY.
  - WVALID drops the cycle after WVALID && WREADY.
  - The two handshakes are independent: either order, or the same cycle.
  - Once both are done, go to WR_RESP. If both complete in the same cycle, go directly to WR_RESP on the next edge.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP, set rsp_write = 1 and rsp_rdata = 0, go to RSP, and drop BREADY.
- RD_REQ: hold ARVALID until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY = 1. On RVALID, capture RDATA/RRESP, set rsp_write = 0, go to RSP, and drop RREADY.
- BREADY/RREADY are never asserted outside WR_RESP/RD_RESP.
- VALIDs are never withdrawn before their handshake. Address, data, strobe and prot stay stable while their VALID is high.
- RSP: rsp_valid = 1, with all rsp_* stable. On rsp_ready, go to IDLE. A new command is accepted one cycle later at the earliest.
- Minimum latency with zero-wait slave:
  - write: accept at cycle 0 → AW/W handshake at cycle 1 → B handshake at cycle 2 → rsp_valid at cycle 3
  - read: same timing
- err_count increments by 1 on every captured response with resp != 2'b00, and saturates at 255.
- Reset mid-transaction: all outputs return to reset values immediately and any in-flight transaction is abandoned. The slave is reset by the same ARESETn.
- Unused inputs are ignored outside their state: stray BVALID in IDLE, and cmd_* while cmd_ready = 0.

Test Plan:
- Write, zero-wait slave: cmd write addr 0x0000_0004, data 0x0000_00A5, wstrb 0xF, prot 0 → AWVALID and WVALID high in cycle 1 with those values. BREADY in cycle 2. In cycle 3 expect rsp_valid = 1, rsp_write = 1, rsp_resp = 0.
- Read after write: read addr 0x0000_0004, slave returns RDATA 0x0000_00A5 with RVALID delayed 3 cycles → RREADY held high the whole time. Expect rsp_rdata = 0x0000_00A5, rsp_write = 0.
- Skewed write channels: WREADY 2 cycles before AWREADY, then the reverse case → each VALID drops independently, BREADY only after both handshakes, exactly one response.
- Error response: slave returns BRESP = 2'b10 on a write to 0x0000_FFFC → rsp_resp = 2'b10, err_count goes 0 → 1. Drive 300 errors → err_count = 255.
- Back-pressure: hold rsp_ready = 0 for 10 cycles → rsp_* stable, cmd_ready = 0, no new AXI activity.
- Reset mid-op: deassert ARESETn while AWVALID = 1 and WREADY is still pending → all outputs 0 immediately. After release, cmd_ready = 1 and a fresh read completes normally.

Source files
------------

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: converts a single-beat command/response port into AXI4-Lite
// read/write transactions, one in flight at a time, with a held response buffer.
module axi4_lite_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    input  logic [2:0]                cmd_prot,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [7:0]                err_count,

    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic [2:0]                AWPROT,
    output logic                      AWVALID,
    input  logic                      AWREADY,

    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,

    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,

    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic [2:0]                ARPROT,
    output logic                      ARVALID,
    input  logic                      ARREADY,

    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RVALID,
    output logic                      RREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t state;

    logic [1:0] resp_in_c;
    logic [7:0] err_next_c;

    assign cmd_ready = (state == IDLE) && ARESETn;

    // Saturating error counter update for whichever response is being captured.
    assign resp_in_c  = (state == RD_RESP) ? RRESP : BRESP;
    assign err_next_c = ((resp_in_c != 2'b00) && (err_count != 8'hFF)) ?
                        err_count + 8'd1 : err_count;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            AWADDR    <= '0;
            AWPROT    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WSTRB     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARPROT    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_write) begin
                            AWADDR  <= cmd_addr;
                            AWPROT  <= cmd_prot;
                            WDATA   <= cmd_wdata;
                            WSTRB   <= cmd_wstrb;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            ARADDR  <= cmd_addr;
                            ARPROT  <= cmd_prot;
                            ARVALID <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end
                // AW and W complete independently; leave once neither is outstanding.
                WR_REQ: begin
                    if (AWREADY) AWVALID <= 1'b0;
                    if (WREADY)  WVALID  <= 1'b0;
                    if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                        BREADY <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_resp  <= BRESP;
                        err_count <= err_next_c;
                        state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (RVALID) begin
                        RREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= RDATA;
                        rsp_resp  <= RRESP;
                        err_count <= err_next_c;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: cycle-stepped slave with per-transaction latencies,
// memory/error-count reference model, directed plus randomized transactions.
module tb_axi4_lite_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          ACLK;
    logic          ARESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [7:0]    err_count;
    logic [AW-1:0] AWADDR;
    logic [2:0]    AWPROT;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic [2:0]    ARPROT;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    logic [DW-1:0] mem [logic [AW-1:0]];

    axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] all_outs();
        return 256'({cmd_ready, AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
                     ARADDR, ARPROT, ARVALID, RREADY, rsp_valid, rsp_write, rsp_rdata,
                     rsp_resp, err_count});
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    task automatic drive_junk_cmd();
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = SW'($urandom);
        cmd_prot  = 3'($urandom);
    endtask

    // One transaction: the slave waits a_lat/w_lat cycles before READY on the request
    // channels and r_lat cycles before the response; the client then stalls hold cycles.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input logic [2:0] prot,
                           input int a_lat, input int w_lat, input int r_lat,
                           input logic [1:0] resp, input int hold);
        int a_wait = 0;
        int w_wait = 0;
        int r_wait = 0;
        int cyc = 0;
        int exp_cyc;
        bit a_req = 1'b0;
        bit w_req = !wr;
        bit a_hs;
        bit w_hs;
        bit r_sched = 1'b0;
        bit done = 1'b0;
        logic [DW-1:0] exp_rdata;
        logic [DW-1:0] cur;

        exp_rdata = wr ? '0 : mem_rd(addr);
        exp_cyc = (wr ? ((a_lat > w_lat) ? a_lat : w_lat) : a_lat) + r_lat + 3;

        @(negedge ACLK);
        check("cmd_ready_idle", 256'(cmd_ready), 256'(1));
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = data; cmd_wstrb = strb; cmd_prot = prot;
        rsp_ready = 1'b0;

        while (!done && cyc < 100) begin
            @(negedge ACLK);
            cyc++;
            drive_junk_cmd();
            AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0; BVALID = 1'b0; RVALID = 1'b0;
            BRESP = 2'($urandom); RRESP = 2'($urandom); RDATA = $urandom;
            a_hs = a_req;
            w_hs = w_req;
            if (r_sched) begin
                check("rsp_latency", 256'(cyc), 256'(exp_cyc));
                done = 1'b1;
            end else begin
                check("rsp_early", 256'(rsp_valid), 256'(0));
                check("cmd_ready_busy", 256'(cmd_ready), 256'(0));
                if (wr) begin
                    check("awvalid", 256'(AWVALID), 256'(!a_hs));
                    check("wvalid", 256'(WVALID), 256'(!w_hs));
                    check("arvalid_in_wr", 256'(ARVALID), 256'(0));
                    check("bready", 256'(BREADY), 256'(a_hs && w_hs));
                    check("rready_in_wr", 256'(RREADY), 256'(0));
                    if (!a_hs) begin
                        check("awaddr", 256'(AWADDR), 256'(addr));
                        check("awprot", 256'(AWPROT), 256'(prot));
                    end
                    if (!w_hs) begin
                        check("wdata", 256'(WDATA), 256'(data));
                        check("wstrb", 256'(WSTRB), 256'(strb));
                    end
                end else begin
                    check("arvalid", 256'(ARVALID), 256'(!a_hs));
                    check("awvalid_in_rd", 256'(AWVALID), 256'(0));
                    check("wvalid_in_rd", 256'(WVALID), 256'(0));
                    check("rready", 256'(RREADY), 256'(a_hs));
                    check("bready_in_rd", 256'(BREADY), 256'(0));
                    if (!a_hs) begin
                        check("araddr", 256'(ARADDR), 256'(addr));
                        check("arprot", 256'(ARPROT), 256'(prot));
                    end
                end
                if (!a_hs) begin
                    if (a_wait == a_lat) begin
                        a_req = 1'b1;
                        if (wr) AWREADY = 1'b1; else ARREADY = 1'b1;
                    end else a_wait++;
                end
                if (!w_hs) begin
                    if (w_wait == w_lat) begin
                        w_req = 1'b1;
                        WREADY = 1'b1;
                    end else w_wait++;
                end
                if (a_hs && w_hs) begin
                    if (r_wait == r_lat) begin
                        r_sched = 1'b1;
                        if (wr) begin
                            BVALID = 1'b1; BRESP = resp;
                        end else begin
                            RVALID = 1'b1; RRESP = resp; RDATA = exp_rdata;
                        end
                    end else r_wait++;
                end
            end
        end
        check("txn_completed", 256'(done), 256'(1));

        if (wr && resp == 2'b00) begin
            cur = mem_rd(addr);
            for (int b = 0; b < int'(SW); b++)
                if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
            mem[addr] = cur;
        end
        if (resp != 2'b00 && exp_err < 255) exp_err++;

        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(negedge ACLK);
                drive_junk_cmd();
                BVALID = 1'($urandom);
            end
            check("rsp_valid", 256'(rsp_valid), 256'(1));
            check("rsp_write", 256'(rsp_write), 256'(wr));
            check("rsp_rdata", 256'(rsp_rdata), 256'(exp_rdata));
            check("rsp_resp", 256'(rsp_resp), 256'(resp));
            check("err_count", 256'(err_count), 256'(exp_err));
            check("cmd_ready_rsp", 256'(cmd_ready), 256'(0));
            check("axi_quiet_rsp", 256'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 256'(0));
        end
        cmd_valid = 1'b0;
        BVALID = 1'b0;
        rsp_ready = 1'b1;
        @(negedge ACLK);
        check("rsp_consumed", 256'(rsp_valid), 256'(0));
        check("cmd_ready_after", 256'(cmd_ready), 256'(1));
        rsp_ready = 1'b0;
        BVALID = 1'($urandom);
        BRESP = 2'b10;
    endtask

    initial begin
        ARESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
        BVALID = 1'b0; BRESP = '0; RVALID = 1'b0; RRESP = '0; RDATA = '0;

        repeat (3) @(negedge ACLK);
        check("reset_outputs", all_outs(), 256'(0));
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("cmd_ready_post_reset", 256'(cmd_ready), 256'(1));

        run_txn(1'b1, 32'h0000_0004, 32'h0000_00A5, 4'hF, 3'd0, 0, 0, 0, 2'b00, 0);
        run_txn(1'b0, 32'h0000_0004, 32'h0,         4'h0, 3'd0, 0, 0, 3, 2'b00, 0);
        run_txn(1'b0, 32'h0000_0004, 32'h0,         4'h0, 3'd5, 2, 0, 1, 2'b00, 0);

        run_txn(1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, 3'd2, 2, 0, 0, 2'b00, 0);
        run_txn(1'b1, 32'h0000_000C, 32'h9ABC_DEF0, 4'h5, 3'd1, 0, 2, 1, 2'b00, 0);
        run_txn(1'b0, 32'h0000_000C, 32'h0,         4'h0, 3'd0, 1, 0, 0, 2'b00, 0);

        run_txn(1'b1, 32'h0000_FFFC, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 0, 0, 2'b10, 0);
        check("err_first", 256'(err_count), 256'(1));

        for (int i = 0; i < 300; i++)
            run_txn(1'b1, 32'h0000_FFFC, DW'(i), 4'hF, 3'd0, 0, 0, 0,
                    (i % 2 == 0) ? 2'b10 : 2'b11, 0);
        check("err_saturated", 256'(err_count), 256'(255));

        run_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'd3, 1, 0, 2, 2'b00, 10);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] r;
            r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(1'($urandom), AW'($urandom_range(0, 15)) << 2, $urandom, SW'($urandom),
                    3'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), r, int'($urandom_range(0, 3)));
        end

        // Abandon a write with both W and AW still waiting on the slave.
        @(negedge ACLK);
        BVALID = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010;
        cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF; cmd_prot = 3'd0;
        @(negedge ACLK);
        cmd_valid = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        check("midop_awvalid", 256'(AWVALID), 256'(1));
        check("midop_wvalid", 256'(WVALID), 256'(1));
        #2 ARESETn = 1'b0;
        #1 check("midop_reset_outputs", all_outs(), 256'(0));
        exp_err = 0;
        mem.delete();
        @(negedge ACLK);
        check("midop_cmd_ready_in_reset", 256'(cmd_ready), 256'(0));
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("midop_cmd_ready_release", 256'(cmd_ready), 256'(1));
        run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 3'd0, 0, 0, 0, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
